// File: rtl/lbp_code_assembler_pkg.sv
// ============================================================================
// lbp_code_assembler_pkg : shared LBP state encoding and Q8.16 sample format
// Revision 1.0
// ============================================================================
`default_nettype none

package lbp_code_assembler_pkg;

  localparam int Q_DATA_W    = 24;
  localparam int Q_FRAC_W    = 16;
  localparam int UNIFORM_MAX = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lbp_uniform_check.sv
// ============================================================================
// lbp_uniform_check : flags a code with at most UNIFORM_MAX circular bit flips
// Revision 1.0
// ============================================================================
`default_nettype none

module lbp_uniform_check
  import lbp_code_assembler_pkg::*;
#(
  parameter int P = 8
) (
  input  logic [P-1:0] code,
  output logic         uniform
);

  logic [P-1:0] diff;
  logic [4:0]   flips;

  // Rotating right by one lines each bit up with its circular neighbour.
  assign diff = code ^ {code[0], code[P-1:1]};

  always_comb begin
    flips = '0;
    for (int i = 0; i < P; i++) begin
      flips = flips + 5'(diff[i]);
    end
    uniform = (flips <= 5'(UNIFORM_MAX));
  end

endmodule

`default_nettype wire

// File: rtl/lbp_code_assembler.sv
// ============================================================================
// lbp_code_assembler : packs P thresholded neighbour samples into an LBP code
// Revision 1.0
// ============================================================================
`default_nettype none

module lbp_code_assembler
  import lbp_code_assembler_pkg::*;
#(
  parameter int P      = 8,
  parameter int DATA_W = Q_DATA_W,
  parameter int FRAC_W = Q_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              first_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [7:0]        center_i,
  output logic              ready_o,
  output logic [P-1:0]      code_o,
  output logic              uniform_o,
  output logic              code_valid_o,
  input  logic              code_ready_i,
  output logic              abort_o
);

  localparam int             CW   = (P > 2) ? $clog2(P) : 1;
  localparam logic [CW-1:0]  LAST = CW'(P - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [7:0]        centre, centre_nxt;
  logic [P-1:0]      acc, acc_nxt;
  logic              accept;
  logic              load;
  logic              abort_nxt;
  logic              sample_bit;
  logic              uni;
  logic [7:0]        cmp_centre;
  logic [DATA_W-1:0] threshold;

  // A first sample is compared against its own centre, not the latched one.
  assign cmp_centre = (accept && first_i) ? center_i : centre;
  assign threshold  = DATA_W'(cmp_centre) << FRAC_W;
  assign sample_bit = (data_i >= threshold);

  lbp_uniform_check #(
    .P (P)
  ) u_uniform (
    .code    (acc_nxt),
    .uniform (uni)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      centre       <= '0;
      acc          <= '0;
      code_o       <= '0;
      uniform_o    <= 1'b0;
      code_valid_o <= 1'b0;
      abort_o      <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      centre  <= centre_nxt;
      acc     <= acc_nxt;
      abort_o <= abort_nxt;
      if (load) begin
        code_o       <= acc_nxt;
        uniform_o    <= uni;
        code_valid_o <= 1'b1;
      end else if (code_ready_i) begin
        code_valid_o <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    centre_nxt = centre;
    acc_nxt    = acc;
    load       = 1'b0;
    abort_nxt  = 1'b0;
    if (accept && first_i) begin
      abort_nxt  = (state == ACCUM);
      centre_nxt = center_i;
      acc_nxt    = '0;
      acc_nxt[0] = sample_bit;
      count_nxt  = CW'(1);
      state_nxt  = ACCUM;
    end else if (accept && state == ACCUM) begin
      acc_nxt[count] = sample_bit;
      if (count == LAST) begin
        load      = 1'b1;
        count_nxt = '0;
        state_nxt = IDLE;
      end else begin
        count_nxt = count + CW'(1);
      end
    end
  end

  // Only the final sample can stall, and only behind an undrained code.
  always_comb begin
    ready_o = !((count == LAST) && code_valid_o && !code_ready_i);
    accept  = valid_i && ready_o;
  end

endmodule

`default_nettype wire

// File: tb/tb_lbp_code_assembler.sv
// ============================================================================
// tb_lbp_code_assembler : directed self-checking bench for lbp_code_assembler
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lbp_code_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        first_i;
  logic [23:0] data_i;
  logic [7:0]  center_i;
  logic        ready_o;
  logic [7:0]  code_o;
  logic        uniform_o;
  logic        code_valid_o;
  logic        code_ready_i;
  logic        abort_o;

  int total = 0;
  int fails = 0;

  lbp_code_assembler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .first_i      (first_i),
    .data_i       (data_i),
    .center_i     (center_i),
    .ready_o      (ready_o),
    .code_o       (code_o),
    .uniform_o    (uniform_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i),
    .abort_o      (abort_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one sample for a single clock edge, then sample outputs #1 later.
  task automatic send(input logic first, input logic [23:0] data, input logic [7:0] centre);
    valid_i  = 1'b1;
    first_i  = first;
    data_i   = data;
    center_i = centre;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    first_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] pat1 [8];
  int abort_seen;

  initial begin
    pat1[0] = 24'h640000; pat1[1] = 24'h63FFFF; pat1[2] = 24'h760000; pat1[3] = 24'h4A0000;
    pat1[4] = 24'h740000; pat1[5] = 24'h000000; pat1[6] = 24'hFFFFFF; pat1[7] = 24'h640001;

    rst_n = 1'b0; valid_i = 1'b0; first_i = 1'b0; data_i = '0; center_i = '0;
    code_ready_i = 1'b1;
    #2;
    chk("rst_code", code_o, 8'h00);
    chk("rst_uniform", uniform_o, 1'b0);
    chk("rst_code_valid", code_valid_o, 1'b0);
    chk("rst_abort", abort_o, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_ready", ready_o, 1'b1);

    // Mixed pattern around centre 100 -> 0xD5, non-uniform.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("p1_not_early", code_valid_o, 1'b0);
      send(i == 0, pat1[i], 8'd100);
    end
    chk("p1_valid_lat1", code_valid_o, 1'b1);
    chk("p1_code", code_o, 8'hD5);
    chk("p1_uniform", uniform_o, 1'b0);
    tick();
    chk("p1_drop_after_hs", code_valid_o, 1'b0);

    // Samples equal to the centre threshold -> all ones, uniform.
    for (int i = 0; i < 8; i++) send(i == 0, 24'h4A0000, 8'd74);
    chk("p2_code", code_o, 8'hFF);
    chk("p2_uniform", uniform_o, 1'b1);
    chk("p2_valid", code_valid_o, 1'b1);
    tick();

    // Restart after three samples must abort exactly once.
    abort_seen = 0;
    send(1'b1, 24'h000000, 8'd50);
    send(1'b0, 24'hFFFFFF, 8'd0);
    send(1'b0, 24'h000000, 8'd0);
    chk("p3_no_abort_yet", abort_o, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(i == 0, 24'h000000 + 24'(i), 8'd0);
      if (abort_o) abort_seen++;
      if (i == 6) chk("p3_no_early_code", code_valid_o, 1'b0);
    end
    chk("p3_abort_once", abort_seen, 1);
    chk("p3_code", code_o, 8'hFF);
    chk("p3_uniform", uniform_o, 1'b1);
    tick();

    // Two codes with downstream stalled; release on the second pixel's last sample.
    code_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(i == 0, (i < 4) ? 24'h700000 : 24'h100000, 8'd100);
    chk("p4_code_a", code_o, 8'h0F);
    chk("p4_uniform_a", uniform_o, 1'b1);
    for (int i = 0; i < 7; i++) begin
      send(i == 0, (i % 2 == 0) ? 24'h640000 : 24'h630000, 8'd100);
      if (i == 1) chk("p4_ready_mid", ready_o, 1'b1);
    end
    valid_i = 1'b1; first_i = 1'b0; data_i = 24'h000000;
    #1;
    chk("p4_ready_low", ready_o, 1'b0);
    tick();
    chk("p4_still_low", ready_o, 1'b0);
    chk("p4_hold_code", code_o, 8'h0F);
    chk("p4_hold_valid", code_valid_o, 1'b1);
    tick();
    chk("p4_hold_code2", code_o, 8'h0F);
    code_ready_i = 1'b1;
    #1;
    chk("p4_ready_release", ready_o, 1'b1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("p5_no_bubble", code_valid_o, 1'b1);
    chk("p5_code_b", code_o, 8'h55);
    chk("p5_uniform_b", uniform_o, 1'b0);
    tick();
    chk("p5_drained", code_valid_o, 1'b0);

    // Reset mid-pixel with a pending code, then a clean pixel.
    code_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(i == 0, 24'h4A0000, 8'd74);
    for (int i = 0; i < 4; i++) send(i == 0, 24'hFFFFFF, 8'd10);
    rst_n = 1'b0;
    #1;
    chk("p6_rst_code", code_o, 8'h00);
    chk("p6_rst_valid", code_valid_o, 1'b0);
    chk("p6_rst_uniform", uniform_o, 1'b0);
    chk("p6_rst_abort", abort_o, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    code_ready_i = 1'b1;
    chk("p6_ready", ready_o, 1'b1);
    send(1'b0, 24'h000000, 8'd1);
    send(1'b0, 24'h00FFFF, 8'd1);
    send(1'b0, 24'h010000, 8'd1);
    send(1'b0, 24'h020000, 8'd1);
    send(1'b0, 24'h010000, 8'd1);
    send(1'b0, 24'hFF0000, 8'd1);
    send(1'b0, 24'h000001, 8'd1);
    send(1'b0, 24'h00FFFF, 8'd1);
    chk("p6_drop_no_first", code_valid_o, 1'b0);
    chk("p6_drop_no_abort", abort_o, 1'b0);
    send(1'b1, 24'h000000, 8'd1);
    send(1'b0, 24'h00FFFF, 8'd1);
    send(1'b0, 24'h010000, 8'd1);
    send(1'b0, 24'h020000, 8'd1);
    send(1'b0, 24'h010000, 8'd1);
    send(1'b0, 24'hFF0000, 8'd1);
    send(1'b0, 24'h000001, 8'd1);
    send(1'b0, 24'h00FFFF, 8'd1);
    chk("p6_valid", code_valid_o, 1'b1);
    chk("p6_code", code_o, 8'h3C);
    chk("p6_uniform", uniform_o, 1'b1);
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

`default_nettype wire
